// File: rtl/tristate_line_pkg.sv
// Shared types and helpers for the tristate single-wire line (receiver and mirror transmitter).
package tristate_line_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

  // Even-parity bit for up to 8 data bits: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/line_sync.sv
// Two-flop synchronizer with a configurable reset value so an idle line reads as released.
module line_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {2{RST_VAL}};
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/tristate_line_rx.sv
// Async serial deframer on the shared pull-up line, with valid/ready byte output.
// Optional even-parity bit and PARITY_ERR output when TRISTATE_LINE_RX_PARITY_EN is defined.
module tristate_line_rx
  import tristate_line_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LINE_IN,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
`ifdef TRISTATE_LINE_RX_PARITY_EN
  ,
  output logic                 PARITY_ERR
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  logic s;

  line_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (LINE_IN),
    .q_o   (s)
  );

  rx_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_BITS-1:0]  sh_q, sh_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  hold_q, hold_d;
  logic                  bad_q, bad_d;
  logic                  perr_q, perr_d;
  logic                  tick;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    ovr_d   = ovr_q;
    hold_d  = hold_q;
    bad_d   = bad_q;

    if (valid_q && RX_READY) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // After a framing error the line may sit low (break); wait for release first.
        if (hold_q) begin
          if (s) hold_d = 1'b0;
        end else if (!s) begin
          cnt_d   = HALF;
          state_d = START;
        end
      end
      START: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else if (s) state_d = IDLE;
        else begin
          cnt_d   = FULL;
          idx_d   = '0;
          bad_d   = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else begin
          sh_d  = {s, sh_q[DATA_BITS-1:1]};
          cnt_d = FULL;
          if (idx_q == LAST) begin
`ifdef TRISTATE_LINE_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef TRISTATE_LINE_RX_PARITY_EN
      PARITY: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else begin
          cnt_d   = FULL;
          bad_d   = (even_parity(8'(sh_q)) != s);
          perr_d  = (even_parity(8'(sh_q)) != s);
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else begin
          state_d = IDLE;
          if (!s) begin
            ferr_d = 1'b1;
            hold_d = 1'b1;
          end else if (!bad_q) begin
            // A byte landing on the same edge the old one is taken simply replaces it.
            if (!valid_q || RX_READY) begin
              data_d  = sh_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      hold_q  <= 1'b0;
      bad_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      hold_q  <= hold_d;
      bad_q   <= bad_d;
      perr_q  <= perr_d;
    end
  end

  assign RX_DATA   = data_q;
  assign RX_VALID  = valid_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
  assign BUSY      = (state_q != IDLE);
`ifdef TRISTATE_LINE_RX_PARITY_EN
  assign PARITY_ERR = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_tristate_line_rx.sv
// Directed bench for tristate_line_rx: line is a tri1 net pulled low by an enabled bench driver.
module tb_tristate_line_rx;

  localparam int CPB = 16;
  localparam int DW  = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          drv_en;
  tri1           line;
  logic [DW-1:0] RX_DATA;
  logic          RX_VALID, RX_READY, FRAME_ERR, OVERRUN, BUSY;
`ifdef TRISTATE_LINE_RX_PARITY_EN
  logic          PARITY_ERR;
`endif

  assign line = drv_en ? 1'b0 : 1'bz;

  always #5 CLK = ~CLK;

  tristate_line_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LINE_IN   (line),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .BUSY      (BUSY)
`ifdef TRISTATE_LINE_RX_PARITY_EN
    ,
    .PARITY_ERR(PARITY_ERR)
`endif
  );

  int ntests = 0, nfail = 0;
  int nxfer, vrun, vmax, nferr, busy_seen, nperr;
  logic fe_prev, fe_long;
  logic [DW-1:0] last_data;

  // Observes pulses and transfers that happen while a frame is being driven.
  always @(negedge CLK) begin
    if (RX_VALID && RX_READY) begin
      nxfer++;
      last_data = RX_DATA;
    end
    vrun = RX_VALID ? vrun + 1 : 0;
    if (vrun > vmax) vmax = vrun;
    if (FRAME_ERR) begin
      nferr++;
      if (fe_prev) fe_long = 1'b1;
    end
    fe_prev = FRAME_ERR;
    if (BUSY) busy_seen = 1;
`ifdef TRISTATE_LINE_RX_PARITY_EN
    if (PARITY_ERR) nperr++;
`endif
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    nxfer = 0; vmax = 0; nferr = 0; fe_long = 1'b0; busy_seen = 0; nperr = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic bit_out(input logic b);
    drv_en = ~b;
    cycles(CPB);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic stopb, input logic parb);
    bit_out(1'b0);
    for (int i = 0; i < DW; i++) bit_out(d[i]);
`ifdef TRISTATE_LINE_RX_PARITY_EN
    bit_out(parb);
`else
    if (parb === 1'bx) $display("note: parity bit unused");
`endif
    bit_out(stopb);
    drv_en = 1'b0;
  endtask

  initial begin
    vrun = 0; fe_prev = 1'b0; last_data = '0;
    clr_mon();
    RST = 1'b1; drv_en = 1'b0; RX_READY = 1'b1;

    // Reset with line released
    cycles(3);
    RST = 1'b0;
    cycles(1);
    chk("rst_valid", RX_VALID, 0);
    chk("rst_data", RX_DATA, 0);
    chk("rst_ferr", FRAME_ERR, 0);
    chk("rst_ovr", OVERRUN, 0);
    chk("rst_busy", BUSY, 0);
    cycles(20);
    chk("idle_no_false_start", busy_seen, 0);

    // Single byte, consumer ready
    clr_mon();
    send(8'hA5, 1'b1, ^8'hA5);
    cycles(5);
    chk("a5_xfer", nxfer, 1);
    chk("a5_data", last_data, 8'hA5);
    chk("a5_valid_width", vmax, 1);
    chk("a5_ferr", nferr, 0);
    chk("a5_valid_low", RX_VALID, 0);

    // Backpressure then overrun
    clr_mon();
    RX_READY = 1'b0;
    send(8'h3C, 1'b1, ^8'h3C);
    cycles(5);
    chk("bp_valid", RX_VALID, 1);
    chk("bp_data", RX_DATA, 8'h3C);
    chk("bp_no_ovr_yet", OVERRUN, 0);
    send(8'hC3, 1'b1, ^8'hC3);
    cycles(5);
    chk("ovr_data_kept", RX_DATA, 8'h3C);
    chk("ovr_set", OVERRUN, 1);
    chk("ovr_valid", RX_VALID, 1);
    RX_READY = 1'b1;
    cycles(1);
    chk("ready_valid_falls", RX_VALID, 0);
    chk("ready_xfer", nxfer, 1);
    chk("ready_xfer_data", last_data, 8'h3C);
    cycles(3);
    chk("ovr_sticky", OVERRUN, 1);

    // Short glitch: start rejected at mid-bit re-sample
    clr_mon();
    drv_en = 1'b1;
    cycles(CPB/4);
    drv_en = 1'b0;
    cycles(30);
    chk("glitch_entered_start", busy_seen, 1);
    chk("glitch_busy", BUSY, 0);
    chk("glitch_xfer", nxfer, 0);
    chk("glitch_ferr", nferr, 0);

    // Framing error then recovery
    clr_mon();
    send(8'h55, 1'b0, ^8'h55);
    cycles(5);
    chk("fe_count", nferr, 1);
    chk("fe_one_cycle", fe_long, 0);
    chk("fe_no_xfer", nxfer, 0);
    chk("fe_valid", RX_VALID, 0);
    send(8'h0F, 1'b1, ^8'h0F);
    cycles(5);
    chk("after_fe_xfer", nxfer, 1);
    chk("after_fe_data", last_data, 8'h0F);
    chk("after_fe_ferr", nferr, 1);

    // Reset during data bit 4
    clr_mon();
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b0);
    cycles(CPB/2);
    chk("midframe_busy", BUSY, 1);
    RST = 1'b1; drv_en = 1'b0;
    cycles(1);
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_valid", RX_VALID, 0);
    RST = 1'b0;
    cycles(200);
    chk("rst_mid_xfer", nxfer, 0);
    chk("rst_mid_ovr_clr", OVERRUN, 0);
    chk("rst_mid_idle", BUSY, 0);

`ifdef TRISTATE_LINE_RX_PARITY_EN
    // Wrong parity: byte dropped
    clr_mon();
    send(8'h01, 1'b1, 1'b0);
    cycles(5);
    chk("par_err_pulse", nperr, 1);
    chk("par_drop", nxfer, 0);
    chk("par_valid", RX_VALID, 0);
    send(8'h81, 1'b1, ^8'h81);
    cycles(5);
    chk("par_ok_xfer", nxfer, 1);
    chk("par_ok_data", last_data, 8'h81);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
